// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/response bundle for the execute unit.
//   Request side : in_valid/in_ready, md_en, alu_control, fn3, rs1_data, rs2_data
//   Response side: out_valid/out_ready, result, zero, div_by_zero
//   master = decode/writeback side, slave = execute unit.
interface alu_muldiv_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic            md_en;
  logic [3:0]      alu_control;
  logic [2:0]      fn3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            div_by_zero;

  modport master (
    output in_valid, md_en, alu_control, fn3, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, result, zero, div_by_zero
  );

  modport slave (
    input  in_valid, md_en, alu_control, fn3, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, result, zero, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: RV32I ALU/branch compare (1 cycle) plus RV32M multiply/divide
// on a shared iterative radix-2 engine (XLEN steps).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_muldiv_seq_if.slave (valid/ready request in, valid/ready result out)
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_seq_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [SHW-1:0]    cnt;
  // Shared engine register: mul = {partial high, multiplier}, div = {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;      // multiplicand (mul) or divisor (div) magnitude
  logic [2:0]        fn_q;
  logic              sa_q, sb_q;
  logic              out_valid_q, zero_q, dbz_q;
  logic [XLEN-1:0]   result_q;

  wire [XLEN-1:0] a = bus.rs1_data;
  wire [XLEN-1:0] b = bus.rs2_data;

  // ---------------- base ALU / branch compare ----------------
  logic [XLEN-1:0] base_res;
  logic            base_zero;
  logic [SHW-1:0]  sh;

  always_comb begin
    sh        = b[SHW-1:0];
    base_res  = '0;
    base_zero = 1'b0;
    case (bus.alu_control)
      4'h0: base_res = a + b;
      4'h1: base_res = a - b;
      4'h2: base_res = a ^ b;
      4'h3: base_res = a | b;
      4'h4: base_res = a & b;
      4'h5: base_res = a << sh;
      4'h6: base_res = a >> sh;
      4'h7: base_res = $signed(a) >>> sh;
      4'h8: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'h9: base_res = {{(XLEN-1){1'b0}}, a < b};
      4'hA: base_zero = (a == b);
      4'hB: base_zero = (a != b);
      4'hC: base_zero = ($signed(a) <  $signed(b));
      4'hD: base_zero = ($signed(a) >= $signed(b));
      4'hE: base_zero = (a <  b);
      4'hF: base_zero = (a >= b);
      default: ;
    endcase
  end

  // ---------------- operand conditioning at accept ----------------
  // Engine always runs on magnitudes; signs are reapplied at the end.
  logic            sa_in, sb_in;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    sa_in = (bus.fn3 inside {3'd1, 3'd2, 3'd4, 3'd6}) && a[XLEN-1];
    sb_in = (bus.fn3 inside {3'd1, 3'd4, 3'd6}) && b[XLEN-1];
    a_mag = sa_in ? -a : a;
    b_mag = sb_in ? -b : b;
  end

  // ---------------- one engine step ----------------
  logic [XLEN:0]     mul_sum, div_sh;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_fix;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, q_fix, r_fix, md_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // Restoring divide: shift in next dividend bit, subtract if it fits.
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opb});
    div_rem  = div_ge ? XLEN'(div_sh - {1'b0, opb}) : div_sh[XLEN-1:0];
    div_next = {div_rem, acc[XLEN-2:0], div_ge};
    step     = fn_q[2] ? div_next : mul_next;
    prod_fix = (sa_q ^ sb_q) ? -step : step;
    q_fix    = (sa_q ^ sb_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
    r_fix    = sa_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    case (fn_q)
      3'd0:          md_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: md_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    md_res = q_fix;
      default:       md_res = r_fix;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      fn_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          if (!bus.md_en) begin
            result_q    <= base_res;
            zero_q      <= base_zero;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (bus.fn3[2] && b == '0) begin
            // Divide by zero short-circuits: quotient all-ones, remainder = dividend
            result_q    <= bus.fn3[1] ? a : '1;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, bus.fn3[2] ? a_mag : b_mag};
            opb   <= bus.fn3[2] ? b_mag : a_mag;
            fn_q  <= bus.fn3;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            result_q    <= md_res;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule
